// File: rtl/pad_filter_pkg.sv
// Shared types and defaults for the pad input debounce filter.
package pad_filter_pkg;

    localparam int DEFAULT_CNT_W = 16;

    typedef enum logic {
        STABLE = 1'b0,
        COUNT  = 1'b1
    } filt_state_e;

endpackage

// File: rtl/pad_sync.sv
// Multi-flop synchronizer for an asynchronous pad input; all stages reset to RESET_VAL.
module pad_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic srst,
    input  logic d,
    output logic q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_reg;
    logic [STAGES-1:0] chain_in;

    assign chain_in[0] = d;

    generate
        for (genvar gi = 1; gi < STAGES; gi++) begin : g_chain
            assign chain_in[gi] = sync_reg[gi-1];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            sync_reg <= {STAGES{RESET_VAL}};
        end else begin
            sync_reg <= chain_in;
        end
    end

    assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/pad_input_debounce.sv
// Debounce filter for a pad input: synchronizer, run-length counter, edge pulses.
// Optional sticky event flag enabled by macro PAD_DEBOUNCE_STICKY_EVT_EN.
module pad_input_debounce
    import pad_filter_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   CNT_W       = DEFAULT_CNT_W,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pad_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] thresh_i,
    output logic             level_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             busy_o,
    input  logic             evt_clr_i,
    output logic             evt_o
);

    logic s;

    pad_sync #(
        .STAGES    (SYNC_STAGES),
        .RESET_VAL (RESET_VAL)
    ) u_sync (
        .clk  (clk_i),
        .srst (rst_i),
        .d    (pad_i),
        .q    (s)
    );

    filt_state_e      state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             level_reg, level_next;
    logic             rise_reg, rise_next;
    logic             fall_reg, fall_next;

    logic [CNT_W-1:0] thr_eff;
    logic [CNT_W:0]   cnt_inc;
    logic             differ;

    // A zero threshold is treated as one so a change is never accepted without a sample.
    assign thr_eff = (thresh_i == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : thresh_i;
    assign cnt_inc = {1'b0, cnt_reg} + {{CNT_W{1'b0}}, 1'b1};
    assign differ  = (s != level_reg);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        level_next = level_reg;
        rise_next  = 1'b0;
        fall_next  = 1'b0;

        if (!en_i) begin
            state_next = STABLE;
            cnt_next   = '0;
        end else begin
            case (state_reg)
                STABLE: begin
                    if (differ) begin
                        if (thr_eff == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                            level_next = s;
                            rise_next  = s;
                            fall_next  = ~s;
                        end else begin
                            cnt_next   = {{(CNT_W-1){1'b0}}, 1'b1};
                            state_next = COUNT;
                        end
                    end
                end
                COUNT: begin
                    // Threshold is compared live, so a lowered value accepts immediately.
                    if (differ) begin
                        if (cnt_inc >= {1'b0, thr_eff}) begin
                            level_next = s;
                            rise_next  = s;
                            fall_next  = ~s;
                            cnt_next   = '0;
                            state_next = STABLE;
                        end else begin
                            cnt_next = cnt_inc[CNT_W-1:0];
                        end
                    end else begin
                        cnt_next   = '0;
                        state_next = STABLE;
                    end
                end
                default: begin
                    cnt_next   = '0;
                    state_next = STABLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg <= STABLE;
            cnt_reg   <= '0;
            level_reg <= RESET_VAL;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            level_reg <= level_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
        end
    end

    assign level_o = level_reg;
    assign rise_o  = rise_reg;
    assign fall_o  = fall_reg;
    assign busy_o  = (state_reg == COUNT);

`ifdef PAD_DEBOUNCE_STICKY_EVT_EN
    logic evt_reg;

    // Set has priority so an event coinciding with a clear is never lost.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            evt_reg <= 1'b0;
        end else if (rise_reg || fall_reg) begin
            evt_reg <= 1'b1;
        end else if (evt_clr_i) begin
            evt_reg <= 1'b0;
        end
    end

    assign evt_o = evt_reg;
`else
    logic unused_evt_clr;
    assign unused_evt_clr = evt_clr_i;
    assign evt_o          = 1'b0;
`endif

endmodule

// File: tb/tb_pad_input_debounce.sv
// Self-checking bench for pad_input_debounce: directed scenarios plus random stimulus
// against a run-length reference model.
module tb_pad_input_debounce;

    localparam int   SYNC_STAGES = 2;
    localparam int   CNT_W       = 16;
    localparam logic RESET_VAL   = 1'b0;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pad = 1'b0;
    logic             en = 1'b0;
    logic [CNT_W-1:0] thresh = '0;
    logic             level, rise, fall, busy;
    logic             evt_clr = 1'b0;
    logic             evt;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: sync delay line, run length of differing samples.
    logic m_syncq[$];
    logic m_level, m_rise, m_fall, m_busy, m_evt;
    int   m_run;

    pad_input_debounce #(
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (CNT_W),
        .RESET_VAL   (RESET_VAL)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .pad_i     (pad),
        .en_i      (en),
        .thresh_i  (thresh),
        .level_o   (level),
        .rise_o    (rise),
        .fall_o    (fall),
        .busy_o    (busy),
        .evt_clr_i (evt_clr),
        .evt_o     (evt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
        end
    endtask

    task automatic model_edge(input logic p, input logic e, input logic r, input logic c,
                              input logic [CNT_W-1:0] th);
        logic s;
        int   th_eff;
        logic nr, nf;
        if (r) begin
            m_syncq = {};
            for (int i = 0; i < SYNC_STAGES; i++) m_syncq.push_back(RESET_VAL);
            m_level = RESET_VAL;
            m_run   = 0;
            m_rise  = 1'b0;
            m_fall  = 1'b0;
            m_busy  = 1'b0;
            m_evt   = 1'b0;
        end else begin
            s = m_syncq.pop_front();
            m_syncq.push_back(p);
`ifdef PAD_DEBOUNCE_STICKY_EVT_EN
            if (m_rise || m_fall) m_evt = 1'b1;
            else if (c)           m_evt = 1'b0;
`else
            m_evt = 1'b0;
`endif
            th_eff = (th == 0) ? 1 : int'(th);
            nr = 1'b0;
            nf = 1'b0;
            if (e && (s != m_level)) begin
                m_run++;
                if (m_run >= th_eff) begin
                    nr      = s;
                    nf      = ~s;
                    m_level = s;
                    m_run   = 0;
                end
            end else begin
                m_run = 0;
            end
            m_rise = nr;
            m_fall = nf;
            m_busy = (m_run != 0);
        end
    endtask

    // One clock: drive on the falling edge, update model at the rising edge, compare just after.
    task automatic step(input logic p, input logic e, input logic r, input logic c,
                        input logic [CNT_W-1:0] th);
        @(negedge clk);
        pad     = p;
        en      = e;
        rst     = r;
        evt_clr = c;
        thresh  = th;
        @(posedge clk);
        model_edge(p, e, r, c, th);
        #1;
        check_eq("level", {31'd0, level}, {31'd0, m_level});
        check_eq("rise",  {31'd0, rise},  {31'd0, m_rise});
        check_eq("fall",  {31'd0, fall},  {31'd0, m_fall});
        check_eq("busy",  {31'd0, busy},  {31'd0, m_busy});
        check_eq("evt",   {31'd0, evt},   {31'd0, m_evt});
        check_eq("rise_fall_excl", {31'd0, rise & fall}, 32'd0);
    endtask

    task automatic hold(input logic p, input logic e, input logic [CNT_W-1:0] th, input int n,
                        output int first_rise, output int first_fall,
                        output int n_rise, output int n_fall, output int n_busy);
        first_rise = 0;
        first_fall = 0;
        n_rise     = 0;
        n_fall     = 0;
        n_busy     = 0;
        for (int i = 0; i < n; i++) begin
            step(p, e, 1'b0, 1'b0, th);
            if (rise && first_rise == 0) first_rise = i + 1;
            if (fall && first_fall == 0) first_fall = i + 1;
            n_rise += int'(rise);
            n_fall += int'(fall);
            n_busy += int'(busy);
        end
    endtask

    initial begin
        int fr, ff, nr, nf, nb;
        int nr2, nf2;
        logic p_r;
        logic [CNT_W-1:0] th_r;

        step(1'b0, 1'b1, 1'b1, 1'b0, 16'd4);
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'd4);
        check_eq("rst_level", {31'd0, level}, {31'd0, RESET_VAL});
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        hold(1'b0, 1'b1, 16'd0, 4, fr, ff, nr, nf, nb);

        // Clean rise with threshold 4.
        hold(1'b1, 1'b1, 16'd4, 10, fr, ff, nr, nf, nb);
        check_eq("clean_rise_latency", fr, 6);
        check_eq("clean_rise_pulses", nr, 1);
        check_eq("clean_rise_busy_cycles", nb, 3);
        check_eq("clean_rise_level", {31'd0, level}, 32'd1);
        hold(1'b0, 1'b1, 16'd0, 4, fr, ff, nr, nf, nb);
        check_eq("return_low_level", {31'd0, level}, 32'd0);

        // Glitch: three synchronized high samples against threshold 4.
        hold(1'b1, 1'b1, 16'd4, 3, fr, ff, nr, nf, nb);
        hold(1'b0, 1'b1, 16'd4, 8, fr, ff, nr2, nf2, nb);
        check_eq("glitch_no_pulse", nr + nr2 + nf + nf2, 0);
        check_eq("glitch_level", {31'd0, level}, 32'd0);
        check_eq("glitch_busy_drop", {31'd0, busy}, 32'd0);

        // Threshold zero behaves as one.
        hold(1'b1, 1'b1, 16'd0, 4, fr, ff, nr, nf, nb);
        check_eq("th0_rise_latency", fr, 3);
        check_eq("th0_rise_pulses", nr, 1);
        hold(1'b0, 1'b1, 16'd0, 4, fr, ff, nr, nf, nb);
        check_eq("th0_fall_latency", ff, 3);
        check_eq("th0_fall_pulses", nf, 1);

        // Threshold drop mid-count: count reaches 10 against 100, then threshold 5.
        hold(1'b1, 1'b1, 16'd100, 12, fr, ff, nr, nf, nb);
        check_eq("drop_no_early_pulse", nr, 0);
        check_eq("drop_busy_before", {31'd0, busy}, 32'd1);
        hold(1'b1, 1'b1, 16'd5, 4, fr, ff, nr, nf, nb);
        check_eq("drop_accept_next", fr, 1);
        check_eq("drop_single_pulse", nr, 1);

        // Enable abort at cnt == thresh-1.
        hold(1'b0, 1'b1, 16'd4, 5, fr, ff, nr, nf, nb);
        check_eq("en_abort_pre_pulse", nf, 0);
        hold(1'b0, 1'b0, 16'd4, 1, fr, ff, nr, nf, nb);
        check_eq("en_abort_no_pulse", nf, 0);
        check_eq("en_abort_busy", {31'd0, busy}, 32'd0);
        check_eq("en_abort_level_held", {31'd0, level}, 32'd1);
        hold(1'b0, 1'b1, 16'd4, 8, fr, ff, nr, nf, nb);
        check_eq("en_recount_latency", ff, 4);

        // Reset abort at cnt == thresh-1.
        hold(1'b1, 1'b1, 16'd0, 4, fr, ff, nr, nf, nb);
        hold(1'b0, 1'b1, 16'd4, 5, fr, ff, nr, nf, nb);
        step(1'b0, 1'b1, 1'b1, 1'b0, 16'd4);
        check_eq("rst_abort_no_pulse", {31'd0, fall | rise}, 32'd0);
        check_eq("rst_abort_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_abort_level", {31'd0, level}, {31'd0, RESET_VAL});
        hold(1'b0, 1'b1, 16'd0, 4, fr, ff, nr, nf, nb);

        // Sticky flag: fall pulse coinciding with clear, then a later clear.
        hold(1'b1, 1'b1, 16'd0, 4, fr, ff, nr, nf, nb);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        step(1'b0, 1'b1, 1'b0, 1'b0, 16'd0);
        check_eq("sticky_fall_seen", {31'd0, fall}, 32'd1);
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'd0);
`ifdef PAD_DEBOUNCE_STICKY_EVT_EN
        check_eq("sticky_set_wins", {31'd0, evt}, 32'd1);
`else
        check_eq("sticky_off_evt", {31'd0, evt}, 32'd0);
`endif
        step(1'b0, 1'b1, 1'b0, 1'b1, 16'd0);
        check_eq("sticky_cleared", {31'd0, evt}, 32'd0);

        // Random stimulus against the model.
        p_r  = 1'b0;
        th_r = 16'd3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) p_r = ~p_r;
            if ($urandom_range(15) == 0) th_r = CNT_W'($urandom_range(6));
            step(p_r, ($urandom_range(15) != 0), ($urandom_range(199) == 0),
                 ($urandom_range(7) == 0), th_r);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
